// File: rtl/imem_loader_if.sv
// ---------------------------------------------------------------------------
// imem_loader_if
//
// Bundles every non-clock/reset signal of the instruction-memory loader.
//
// Host/control side (driven by the master):
//   start       begin a load (only looked at while the loader is idle)
//   base_addr   first instruction address to write
//   word_count  number of 16-bit words to load, 0 means an empty load
//   abort       terminate the current load immediately
//   in_data     byte from the host link
//   in_valid    in_data is valid
//
// Loader side (driven by the slave):
//   in_ready    loader accepts a byte on this cycle's rising edge
//   wr_en       one-cycle instruction-memory write strobe
//   wr_addr     write address, qualified by wr_en
//   wr_data     write data {hi_byte, lo_byte}, qualified by wr_en
//   cpu_hold    CPU must stall while high
//   busy        load in progress
//   done        one-cycle pulse on normal completion
//
// Modports:
//   master  host / debug link side
//   slave   the loader itself
// ---------------------------------------------------------------------------
interface imem_loader_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] word_count;
  logic              abort;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              cpu_hold;
  logic              busy;
  logic              done;

  modport master (
    output start,
    output base_addr,
    output word_count,
    output abort,
    output in_data,
    output in_valid,
    input  in_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  cpu_hold,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  base_addr,
    input  word_count,
    input  abort,
    input  in_data,
    input  in_valid,
    output in_ready,
    output wr_en,
    output wr_addr,
    output wr_data,
    output cpu_hold,
    output busy,
    output done
  );

endinterface

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Write-side companion to the instruction memory's combinational read port.
// A byte stream from a host/debug link is assembled into 16-bit instruction
// words (high byte first); each completed word is written with a single-cycle
// strobe to consecutive addresses starting at a programmed base. While a load
// is in progress the CPU is held.
//
// Ports:
//   clk   single clock, all state changes on the rising edge
//   rst   asynchronous, active-high reset
//   bus   imem_loader_if.slave carrying the start/abort controls, the byte
//         handshake (in_data/in_valid/in_ready), the memory write port
//         (wr_en/wr_addr/wr_data) and the status outputs (cpu_hold/busy/done)
//
// Every output is Moore: decoded from the state register or taken straight
// from registered datapath, so nothing combinational leaks from inputs.
// ---------------------------------------------------------------------------
module imem_loader #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  imem_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_HI,
    S_LOAD_LO,
    S_WRITE,
    S_DONE
  } state_t;

  state_t            state_q,     state_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [ADDR_W-1:0] remaining_q, remaining_d;
  logic [7:0]        hi_q,        hi_d;
  logic [ADDR_W-1:0] wr_addr_q,   wr_addr_d;
  logic [DATA_W-1:0] wr_data_q,   wr_data_d;

  logic byte_accept;

  // in_ready is purely state-decoded, so a byte is taken whenever the host
  // offers one in either load state.
  assign byte_accept = bus.in_valid &&
                       ((state_q == S_LOAD_HI) || (state_q == S_LOAD_LO));

  // Next-state and datapath. wr_addr/wr_data live in their own registers,
  // loaded only when a word is complete, so they keep showing the last write
  // after addr_q has moved on to the next address.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    hi_d        = hi_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;

    unique case (state_q)
      S_IDLE: begin
        // abort sitting on the line blocks a start in the same cycle
        if (bus.start && !bus.abort) begin
          addr_d      = bus.base_addr;
          remaining_d = bus.word_count;
          if (bus.word_count == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD_HI;
          end
        end
      end

      S_LOAD_HI: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (byte_accept) begin
          hi_d    = bus.in_data;
          state_d = S_LOAD_LO;
        end
      end

      S_LOAD_LO: begin
        // Abort wins over a byte arriving in the same cycle; the half-built
        // word is simply dropped and the write registers are left untouched.
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (byte_accept) begin
          wr_addr_d = addr_q;
          wr_data_d = {hi_q, bus.in_data};
          state_d   = S_WRITE;
        end
      end

      S_WRITE: begin
        // The strobe is already on the bus this cycle, so the word counts as
        // written even if abort arrives now; advance the pointers regardless.
        addr_d      = addr_q + 1'b1;
        remaining_d = remaining_q - 1'b1;
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (remaining_q == ADDR_W'(1)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_LOAD_HI;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset clears everything, including the
  // visible write address/data, so a reset mid-load never leaves a stale
  // word looking like a pending write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      hi_q        <= '0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      hi_q        <= hi_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  // Moore output decode.
  assign bus.in_ready = (state_q == S_LOAD_HI) || (state_q == S_LOAD_LO);
  assign bus.wr_en    = (state_q == S_WRITE);
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.busy     = (state_q == S_LOAD_HI) || (state_q == S_LOAD_LO) ||
                        (state_q == S_WRITE);
  assign bus.cpu_hold = bus.busy;
  assign bus.done     = (state_q == S_DONE);

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Write-side companion to the instruction memory's combinational read port.
- Takes a byte stream from a host/debug link, assembles 16-bit instruction words (high byte first) and issues single-cycle writes to consecutive instruction-memory addresses from a programmed base.
- Asserts a hold to the CPU while a load is in progress.

Parameters:
- ADDR_W, 16: instruction address width; addresses wrap modulo 2^ADDR_W.
- DATA_W, 16: instruction word width. Fixed at 16, two bytes per word; other values unsupported.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a load; sampled only in IDLE.
- base_addr  in  ADDR_W  first write address; captured on accepted start.
- word_count  in  ADDR_W  number of words to load; captured on accepted start; 0 = empty load.
- abort  in  1  terminate the load immediately.
- in_data  in  8  byte from host.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader can accept a byte this cycle.
- wr_en  out  1  instruction-memory write strobe, one cycle per word.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  16  write data {hi_byte, lo_byte}.
- cpu_hold  out  1  CPU must stall/hold PC while high.
- busy  out  1  load in progress.
- done  out  1  one-cycle pulse on normal completion.

Behaviour:
- Decided: one clock; reset asynchronous and active-high.
- States: IDLE, LOAD_HI, LOAD_LO, WRITE, DONE. All outputs are Moore, decoded from registered state/datapath.
- Reset (async, any state, including mid-load): state=IDLE; in_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_hold=0, busy=0, done=0; word index and remaining count cleared. No partial write is ever issued after reset.
- Byte handshake: a byte is accepted on a rising edge where in_valid&&in_ready. in_ready=1 only in LOAD_HI and LOAD_LO. in_valid with in_ready=0 is ignored (host holds data).
- IDLE:
  - start=1 && abort=0: capture base_addr into addr register and word_count into remaining.
  - If word_count==0, go to DONE; else go to LOAD_HI.
- LOAD_HI: on byte accept, hi_reg<=in_data and go to LOAD_LO.
- LOAD_LO: on byte accept, lo_reg<=in_data and go to WRITE.
- WRITE:
  - Outputs: wr_en=1, wr_addr=addr register, wr_data={hi_reg,lo_reg}; held exactly one cycle.
  - Next edge: addr<=addr+1 (wraps 2^ADDR_W-1 -> 0); remaining<=remaining-1.
  - If remaining==1, go to DONE; else go to LOAD_HI.
- DONE: done=1 for exactly one cycle, then IDLE.
- busy=cpu_hold=1 in LOAD_HI, LOAD_LO, WRITE; 0 in IDLE and DONE.
- wr_addr/wr_data hold last values outside WRITE; only wr_en qualifies them.
- Latency: start to first in_ready is 1 cycle. Minimum 3 cycles per word (hi, lo, write). Last write to done is 1 cycle.
- abort: in LOAD_HI, LOAD_LO or WRITE, the next state is IDLE.
  - done is not pulsed.
  - A write asserted in the same WRITE cycle as abort still occurs (wr_en is Moore); no further writes.
  - A partially assembled word is discarded.
- abort in IDLE overrides start; start outside IDLE is ignored.
- word_count is up to 2^ADDR_W-1; a full 2^ADDR_W load takes two loads.

Test Plan:
- Reset, then base=0x0010, count=2, bytes 12,34,AB,CD at full rate -> writes addr 0x0010=0x1234, 0x0011=0xABCD; wr_en pulses 3 cycles apart; done one cycle after second write; cpu_hold high from cycle after start through last WRITE.
- count=0 -> no wr_en, in_ready stays 0, done pulses cycle after start, busy never high.
- base=0xFFFF, count=2, bytes 00,01,00,02 -> writes 0xFFFF=0x0001 then 0x0000=0x0002 (wrap).
- in_valid toggled 1-of-3 cycles with count=1, bytes 5A,A5 -> single write 0x5AA5; no write or state change while in_valid=0.
- abort after the hi byte of word 2 (count=3) -> word 1 written only; idle next cycle, no done, cpu_hold low; a new start then loads normally.
- async rst asserted mid-LOAD_LO -> all outputs 0 immediately, no wr_en; start after release begins a fresh load.
